uart_fifo: RTL and testbench

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo.sv | 213 +++++++++++++++++++++
 tb/tb_uart_fifo.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// uart_fifo -- TX/RX byte FIFOs bridging a CPU register port to a UART core.
// Revision 1.0
`default_nettype none

module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_wdata,
  input  logic                     cpu_re,
  output logic [31:0]              cpu_rdata,
  output logic                     u_we,
  output logic [31:0]              u_so,
  input  logic                     u_wa,
  output logic                     u_re,
  input  logic [31:0]              u_si,
  output logic                     tx_full,
  output logic                     tx_empty,
  output logic                     rx_full,
  output logic                     rx_empty,
  output logic                     tx_ovf,
  output logic                     rx_ovf,
  output logic [$clog2(DEPTH):0]   rx_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {T_IDLE = 2'd0, T_SEND = 2'd1, T_BUSY = 2'd2} tx_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_ACK = 1'b1} rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wptr;
  logic [AW-1:0] tx_rptr;
  logic [CW-1:0] tx_cnt;
  logic          tx_push;
  logic          tx_pop;
  logic [7:0]    tx_hold;
  tx_state_t     tx_state;
  tx_state_t     tx_next;

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  // Fullness is judged before any same-cycle drain, so a push into a full FIFO is dropped.
  assign tx_push  = cpu_we && !tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wptr] <= cpu_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
      tx_ovf  <= 1'b0;
    end else begin
      if (tx_push) begin
        tx_wptr <= tx_wptr + AW'(1);
      end
      if (tx_pop) begin
        tx_rptr <= tx_rptr + AW'(1);
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
      if (cpu_we && tx_full) begin
        tx_ovf <= 1'b1;
      end
    end
  end

  // ---------------- TX drain FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
    end else begin
      tx_state <= tx_next;
    end
  end

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    u_we    = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (!tx_empty && !u_wa) begin
          tx_pop  = 1'b1;
          tx_next = T_SEND;
        end
      end
      T_SEND: begin
        u_we    = 1'b1;
        tx_next = T_BUSY;
      end
      T_BUSY: begin
        if (!u_wa) begin
          tx_next = T_IDLE;
        end
      end
      default: tx_next = T_IDLE;
    endcase
  end

  // The holding register doubles as the u_so source, so u_so keeps the last byte sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_hold <= '0;
    end else if (tx_pop) begin
      tx_hold <= tx_mem[tx_rptr];
    end
  end

  assign u_so = {24'h0, tx_hold};

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wptr;
  logic [AW-1:0] rx_rptr;
  logic [CW-1:0] rx_cnt;
  logic          rx_push;
  logic          rx_pop;
  logic          rx_drop;
  logic          rx_valid;
  rx_state_t     rx_state;
  rx_state_t     rx_next;

  assign rx_full   = (rx_cnt == FULL_CNT);
  assign rx_empty  = (rx_cnt == '0);
  assign rx_count  = rx_cnt;
  assign rx_valid  = !u_si[31];
  assign rx_pop    = cpu_re && !rx_empty;
  assign cpu_rdata = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_mem[rx_rptr]};

  // On a full FIFO with a concurrent pop, wptr equals rptr: the head is consumed this cycle.
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wptr] <= u_si[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_cnt  <= '0;
      rx_ovf  <= 1'b0;
    end else begin
      if (rx_push) begin
        rx_wptr <= rx_wptr + AW'(1);
      end
      if (rx_pop) begin
        rx_rptr <= rx_rptr + AW'(1);
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      if (rx_drop) begin
        rx_ovf <= 1'b1;
      end
    end
  end

  // ---------------- RX capture FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= R_IDLE;
    end else begin
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    rx_drop = 1'b0;
    u_re    = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (rx_valid) begin
          if (!rx_full || rx_pop) begin
            rx_push = 1'b1;
            rx_next = R_ACK;
          end else begin
            rx_drop = 1'b1;
          end
        end
      end
      R_ACK: begin
        u_re    = 1'b1;
        rx_next = R_IDLE;
      end
      default: rx_next = R_IDLE;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{cpu_wdata[31:8], u_si[30:8]};

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo -- directed/randomized bench for uart_fifo with queue-based UART and FIFO models.
// Revision 1.0
`default_nettype none

module tb_uart_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_we;
  logic [31:0]   cpu_wdata;
  logic          cpu_re;
  logic [31:0]   cpu_rdata;
  logic          u_we;
  logic [31:0]   u_so;
  logic          u_wa;
  logic          u_re;
  logic [31:0]   u_si;
  logic          tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_ovf;
  logic [CW-1:0] rx_count;

  uart_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata),
    .u_we(u_we), .u_so(u_so), .u_wa(u_wa), .u_re(u_re), .u_si(u_si),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
    .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // UART-side models: bytes the transmitter received, bytes waiting in the receiver.
  logic [31:0] tx_seen [$];
  logic [7:0]  tx_exp  [$];
  logic [7:0]  rx_src  [$];
  logic [7:0]  rx_exp  [$];
  logic        wa_auto = 1'b0;
  int          busy_left = 0;
  logic        we_prev = 1'b0;
  int          we_double = 0;
  int          we_busy = 0;
  int          acks = 0;
  int          bad_acks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_si();
    if (rx_src.size() != 0) u_si = {24'h0, rx_src[0]};
    else                    u_si = 32'h8000_0000 | $urandom();
  endtask

  // One clock: capture strobes seen at the edge, advance the UART models, settle inputs.
  task automatic tick();
    logic        ack_now, we_now, wa_now;
    logic [31:0] so_now;
    ack_now = u_re; we_now = u_we; so_now = u_so; wa_now = u_wa;
    @(posedge clk);
    #1;
    if (we_now) begin
      tx_seen.push_back(so_now);
      if (we_prev) we_double++;
      if (wa_now)  we_busy++;
      if (wa_auto) busy_left = $urandom_range(1, 4);
    end
    we_prev = we_now;
    if (ack_now) begin
      acks++;
      if (rx_src.size() != 0) void'(rx_src.pop_front());
      else bad_acks++;
    end
    if (wa_auto) begin
      u_wa = (busy_left != 0);
      if (busy_left != 0) busy_left--;
    end
    drive_si();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_wdata = '0;
    wa_auto = 1'b0; u_wa = 1'b0; busy_left = 0;
    rx_src.delete(); rx_exp.delete(); tx_seen.delete(); tx_exp.delete();
    we_prev = 1'b0; we_double = 0; we_busy = 0; acks = 0; bad_acks = 0;
    drive_si();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic push_tx(input logic [7:0] b, input logic keep);
    logic [31:0] w;
    w = $urandom();
    w[7:0] = b;
    cpu_wdata = w;
    cpu_we = 1'b1;
    if (keep) tx_exp.push_back(b);
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int max_cycles);
    int c = 0;
    while (tx_seen.size() < n && c < max_cycles) begin tick(); c++; end
    repeat (6) tick();
  endtask

  task automatic check_tx(input string tag);
    check({tag, "_count"}, 32'(tx_seen.size()), 32'(tx_exp.size()));
    for (int i = 0; i < tx_exp.size() && i < tx_seen.size(); i++)
      check({tag, "_byte"}, tx_seen[i], {24'h0, tx_exp[i]});
    check({tag, "_double_we"}, 32'(we_double), 32'd0);
    check({tag, "_we_while_busy"}, 32'(we_busy), 32'd0);
    check({tag, "_tx_empty"}, 32'(tx_empty), 32'd1);
  endtask

  task automatic read_rx(input string tag);
    logic [7:0] e;
    while (rx_exp.size() != 0) begin
      int w = 0;
      while (rx_empty && w < 20) begin tick(); w++; end
      e = rx_exp.pop_front();
      check(tag, cpu_rdata, {24'h0, e});
      cpu_re = 1'b1;
      tick();
      cpu_re = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_u_we"},     32'(u_we),     32'd0);
    check({tag, "_u_re"},     32'(u_re),     32'd0);
    check({tag, "_u_so"},     u_so,          32'd0);
    check({tag, "_tx_empty"}, 32'(tx_empty), 32'd1);
    check({tag, "_rx_empty"}, 32'(rx_empty), 32'd1);
    check({tag, "_tx_full"},  32'(tx_full),  32'd0);
    check({tag, "_rx_full"},  32'(rx_full),  32'd0);
    check({tag, "_tx_ovf"},   32'(tx_ovf),   32'd0);
    check({tag, "_rx_ovf"},   32'(rx_ovf),   32'd0);
    check({tag, "_rx_count"}, 32'(rx_count), 32'd0);
    check({tag, "_cpu_rdata"}, cpu_rdata,    32'hFFFF_FFFF);
  endtask

  initial begin
    logic [7:0]  b, rb;
    logic [31:0] held;

    // Reset values, observed before any clock edge.
    rst_n = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_wdata = '0; u_wa = 1'b0;
    u_si = 32'h8000_0000;
    #2;
    check_reset_outputs("reset");
    do_reset();

    // Two bytes straight through with an idle transmitter.
    push_tx(8'h41, 1'b1);
    push_tx(8'h42, 1'b1);
    wait_tx(2, 40);
    check_tx("tx_pair");

    // Nine pushes against a busy transmitter: eight stored, the ninth dropped.
    do_reset();
    u_wa = 1'b1;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom());
      push_tx(b, i < 8);
      if (i == 7) begin
        check("fill_tx_full", 32'(tx_full), 32'd1);
        check("fill_tx_ovf_clear", 32'(tx_ovf), 32'd0);
      end
    end
    check("ovf_tx_ovf", 32'(tx_ovf), 32'd1);
    check("ovf_tx_full", 32'(tx_full), 32'd1);
    check("ovf_no_send", 32'(tx_seen.size()), 32'd0);
    wa_auto = 1'b1; u_wa = 1'b0;
    wait_tx(8, 300);
    check_tx("tx_drain");
    check("ovf_sticky", 32'(tx_ovf), 32'd1);

    // Push into a full TX on the same edge the drain pops: push is still dropped.
    do_reset();
    u_wa = 1'b1;
    for (int i = 0; i < 8; i++) push_tx(8'($urandom()), 1'b1);
    u_wa = 1'b0; wa_auto = 1'b1;
    push_tx(8'hEE, 1'b0);
    check("race_tx_ovf", 32'(tx_ovf), 32'd1);
    check("race_tx_full", 32'(tx_full), 32'd0);
    wait_tx(8, 300);
    check_tx("race_drain");

    // Single received byte, ack timing, non-destructive read, then pop.
    do_reset();
    rx_src.push_back(8'h55); drive_si();
    tick();
    check("rx1_u_re", 32'(u_re), 32'd1);
    check("rx1_count", 32'(rx_count), 32'd1);
    tick();
    check("rx1_u_re_low", 32'(u_re), 32'd0);
    check("rx1_rdata", cpu_rdata, 32'h0000_0055);
    tick();
    check("rx1_peek", cpu_rdata, 32'h0000_0055);
    cpu_re = 1'b1; tick(); cpu_re = 1'b0;
    check("rx1_popped", cpu_rdata, 32'hFFFF_FFFF);
    check("rx1_empty", 32'(rx_empty), 32'd1);
    cpu_re = 1'b1; tick(); cpu_re = 1'b0;
    check("rx_pop_empty", 32'(rx_count), 32'd0);

    // Ten bytes offered: eight captured, two left waiting with no ack.
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom());
      rx_src.push_back(rb); rx_exp.push_back(rb);
    end
    drive_si();
    repeat (40) tick();
    check("rxfull_count", 32'(rx_count), 32'(DEPTH));
    check("rxfull_full", 32'(rx_full), 32'd1);
    check("rxfull_ovf", 32'(rx_ovf), 32'd1);
    check("rxfull_u_re", 32'(u_re), 32'd0);
    check("rxfull_acks", 32'(acks), 32'(DEPTH));
    check("rxfull_left", 32'(rx_src.size()), 32'd2);

    // Pop on a full RX while a byte is waiting: swap in place, order kept.
    check("swap_head", cpu_rdata, {24'h0, rx_exp[0]});
    cpu_re = 1'b1; tick(); cpu_re = 1'b0;
    check("swap_count", 32'(rx_count), 32'(DEPTH));
    check("swap_u_re", 32'(u_re), 32'd1);
    void'(rx_exp.pop_front());
    read_rx("rx_order");
    repeat (4) tick();
    check("rx_drained_src", 32'(rx_src.size()), 32'd0);
    check("rx_drained_empty", 32'(rx_empty), 32'd1);
    check("rx_ovf_sticky", 32'(rx_ovf), 32'd1);
    check("rx_bad_acks", 32'(bad_acks), 32'd0);

    // Random mixed traffic on both directions.
    do_reset();
    wa_auto = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      if (i < 6) begin
        rb = 8'($urandom());
        rx_src.push_back(rb); rx_exp.push_back(rb);
        drive_si();
      end
      push_tx(8'($urandom()), 1'b1);
    end
    wait_tx(8, 300);
    check_tx("mix_tx");
    read_rx("mix_rx");
    check("mix_tx_ovf", 32'(tx_ovf), 32'd0);
    check("mix_rx_ovf", 32'(rx_ovf), 32'd0);

    // Asynchronous reset while the transmitter is busy.
    do_reset();
    b = 8'($urandom_range(1, 255));
    push_tx(b, 1'b0);
    tick();
    check("abort_send", 32'(u_we), 32'd1);
    u_wa = 1'b1;
    rx_src.push_back(8'h3C); drive_si();
    tick(); tick();
    held = u_so;
    check("abort_held", held, {24'h0, b});
    check("abort_rx_count", 32'(rx_count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
